// File: rtl/key_entry_calc.sv
// rtl/key_entry_calc.sv - keypad two-operand +/- calculator with serial double-dabble BCD output
// Optional KEY_ERR_EN: one-cycle err strobe after any rejected key; otherwise err is tied low.
module key_entry_calc #(
  parameter int DIGITS = 2,
  parameter int BW     = 4*DIGITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_pulse,
  input  logic [8:0]              key_code,
  output logic [4*(DIGITS+1)-1:0] disp_bcd,
  output logic                    neg,
  output logic [1:0]              op_code,
  output logic                    busy,
  output logic                    done_pulse,
  output logic                    err
);
  localparam int DW = 4*(DIGITS+1);
  localparam int OW = 4*DIGITS;
  localparam int CW = $clog2(BW+1);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, DONE} state_t;
  state_t state;

  logic [BW-1:0] a_bin, b_bin, mag;
  logic [OW-1:0] a_bcd, b_bcd;
  logic [2:0]    a_cnt, b_cnt;
  logic [DW-1:0] dd_bcd, dd_adj, dd_next;
  logic [CW-1:0] calc_cnt;
  logic          neg_n;
  logic          is_digit, is_add, is_sub, is_enter, is_esc, a_full, b_full;
  logic [3:0]    digit;

  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (key_code)
      9'h045: digit = 4'd0;
      9'h016: digit = 4'd1;
      9'h01E: digit = 4'd2;
      9'h026: digit = 4'd3;
      9'h025: digit = 4'd4;
      9'h02E: digit = 4'd5;
      9'h036: digit = 4'd6;
      9'h03D: digit = 4'd7;
      9'h03E: digit = 4'd8;
      9'h046: digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
    is_add   = (key_code == 9'h079);
    is_sub   = (key_code == 9'h07B);
    is_enter = (key_code == 9'h05A) || (key_code == 9'h15A);
    is_esc   = (key_code == 9'h076);
    a_full   = (a_cnt == 3'(DIGITS));
    b_full   = (b_cnt == 3'(DIGITS));
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next magnitude bit.
  always_comb begin
    dd_adj = dd_bcd;
    for (int i = 0; i < DIGITS+1; i++)
      if (dd_bcd[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = dd_bcd[4*i +: 4] + 4'd3;
    dd_next = DW'({dd_adj, mag[BW-1]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ENTER_A;
      a_bin      <= '0;
      b_bin      <= '0;
      a_bcd      <= '0;
      b_bcd      <= '0;
      a_cnt      <= '0;
      b_cnt      <= '0;
      mag        <= '0;
      dd_bcd     <= '0;
      calc_cnt   <= '0;
      neg_n      <= 1'b0;
      disp_bcd   <= '0;
      neg        <= 1'b0;
      op_code    <= 2'd0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (key_pulse && is_esc && state != CALC) begin
        state    <= ENTER_A;
        a_bin    <= '0;
        b_bin    <= '0;
        a_bcd    <= '0;
        b_bcd    <= '0;
        a_cnt    <= '0;
        b_cnt    <= '0;
        disp_bcd <= '0;
        neg      <= 1'b0;
        op_code  <= 2'd0;
      end else begin
        case (state)
          ENTER_A: if (key_pulse) begin
            if (is_digit && !a_full) begin
              a_bin    <= a_bin * BW'(10) + BW'(digit);
              a_bcd    <= OW'({a_bcd, digit});
              a_cnt    <= a_cnt + 3'd1;
              disp_bcd <= DW'(OW'({a_bcd, digit}));
            end else if (is_add || is_sub) begin
              op_code  <= is_add ? 2'd1 : 2'd2;
              disp_bcd <= '0;
              state    <= ENTER_B;
            end
          end
          ENTER_B: if (key_pulse) begin
            if (is_digit && !b_full) begin
              b_bin    <= b_bin * BW'(10) + BW'(digit);
              b_bcd    <= OW'({b_bcd, digit});
              b_cnt    <= b_cnt + 3'd1;
              disp_bcd <= DW'(OW'({b_bcd, digit}));
            end else if ((is_add || is_sub) && b_cnt == 3'd0) begin
              op_code <= is_add ? 2'd1 : 2'd2;
            end else if (is_enter) begin
              state    <= CALC;
              busy     <= 1'b1;
              calc_cnt <= '0;
            end
          end
          CALC: begin
            calc_cnt <= calc_cnt + 1'b1;
            if (calc_cnt == '0) begin
              dd_bcd <= '0;
              if (op_code == 2'd2 && a_bin < b_bin) begin
                mag   <= b_bin - a_bin;
                neg_n <= 1'b1;
              end else begin
                mag   <= (op_code == 2'd2) ? a_bin - b_bin : a_bin + b_bin;
                neg_n <= 1'b0;
              end
            end else begin
              dd_bcd <= dd_next;
              mag    <= mag << 1;
              if (calc_cnt == CW'(BW)) begin
                state      <= DONE;
                busy       <= 1'b0;
                done_pulse <= 1'b1;
                disp_bcd   <= dd_next;
                neg        <= neg_n;
              end
            end
          end
          DONE: if (key_pulse && is_digit) begin
            a_bin    <= BW'(digit);
            a_bcd    <= OW'(digit);
            a_cnt    <= 3'd1;
            b_bin    <= '0;
            b_bcd    <= '0;
            b_cnt    <= '0;
            op_code  <= 2'd0;
            neg      <= 1'b0;
            disp_bcd <= DW'(digit);
            state    <= ENTER_A;
          end
          default: state <= ENTER_A;
        endcase
      end
    end
  end

`ifdef KEY_ERR_EN
  logic reject, is_known;

  always_comb begin
    is_known = is_digit || is_add || is_sub || is_enter || is_esc;
    reject   = 1'b0;
    if (key_pulse) begin
      case (state)
        ENTER_A: reject = !is_known || (is_digit && a_full) || is_enter;
        ENTER_B: reject = !is_known || (is_digit && b_full) || ((is_add || is_sub) && b_cnt != 3'd0);
        CALC:    reject = 1'b1;
        DONE:    reject = !is_known || is_add || is_sub || is_enter;
        default: reject = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= reject;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_key_entry_calc.sv
// tb/tb_key_entry_calc.sv - directed bench for key_entry_calc with a result scoreboard
// Honors KEY_ERR_EN when defined for the bench compile as well.
module tb_key_entry_calc;
  localparam int DIGITS = 2;
  localparam int DW = 4*(DIGITS+1);
`ifdef KEY_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  localparam logic [8:0] K_ADD = 9'h079, K_SUB = 9'h07B, K_ENT = 9'h05A;
  localparam logic [8:0] K_ENTX = 9'h15A, K_ESC = 9'h076, K_UNK = 9'h01C;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_pulse = 1'b0;
  logic [8:0]    key_code = 9'h000;
  logic [DW-1:0] disp_bcd;
  logic          neg, busy, done_pulse, err;
  logic [1:0]    op_code;

  typedef struct packed {
    logic [DW-1:0] bcd;
    logic          neg;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int passed = 0;
  int failed = 0;

  key_entry_calc #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .key_code(key_code),
    .disp_bcd(disp_bcd), .neg(neg), .op_code(op_code), .busy(busy),
    .done_pulse(done_pulse), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] kd(input int d);
    case (d)
      0: return 9'h045;
      1: return 9'h016;
      2: return 9'h01E;
      3: return 9'h026;
      4: return 9'h025;
      5: return 9'h02E;
      6: return 9'h036;
      7: return 9'h03D;
      8: return 9'h03E;
      9: return 9'h046;
      default: return 9'h000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [8:0] code);
    key_pulse = 1'b1;
    key_code  = code;
    tick();
    key_pulse = 1'b0;
    key_code  = 9'h000;
  endtask

  task automatic enter(input logic [8:0] code, input logic [DW-1:0] bcd, input logic n);
    exp_t e;
    e.bcd = bcd;
    e.neg = n;
    sb.push_back(e);
    press(code);
  endtask

  // pre = busy cycles already consumed by keys injected after Enter
  task automatic wait_done(input int pre);
    int n;
    exp_t e;
    n = pre;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("busy_len", n, 9);
    chk("done_pulse", done_pulse, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("result_bcd", disp_bcd, e.bcd);
      chk("result_neg", neg, e.neg);
    end else begin
      total++;
      failed++;
      $error("FAIL sb_underflow: observed result with no expectation queued");
    end
    tick();
    chk("done_one_cycle", done_pulse, 0);
  endtask

  task automatic ab(input int a1, input int a0, input logic [8:0] op, input int b1, input int b0);
    press(kd(a1));
    press(kd(a0));
    press(op);
    press(kd(b1));
    press(kd(b0));
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_disp", disp_bcd, 0);
    chk("rst_neg", neg, 0);
    chk("rst_op", op_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 12 + 34
    press(kd(1));
    chk("t1_a1", disp_bcd, 12'h001);
    press(kd(2));
    chk("t1_a12", disp_bcd, 12'h012);
    press(K_ADD);
    chk("t1_op_add", op_code, 1);
    chk("t1_b_blank", disp_bcd, 12'h000);
    press(kd(3));
    press(kd(4));
    chk("t1_b34", disp_bcd, 12'h034);
    enter(K_ENT, 12'h046, 1'b0);
    chk("t1_busy", busy, 1);
    wait_done(0);

    // 15 - 40 from DONE, then 40 - 40
    press(kd(1));
    chk("t2_restart", disp_bcd, 12'h001);
    chk("t2_op_clr", op_code, 0);
    press(kd(5));
    press(K_SUB);
    chk("t2_op_sub", op_code, 2);
    press(kd(4));
    press(kd(0));
    chk("t2_b40", disp_bcd, 12'h040);
    enter(K_ENTX, 12'h025, 1'b1);
    wait_done(0);
    press(kd(4));
    chk("t2_neg_clr", neg, 0);
    press(kd(0));
    press(K_SUB);
    press(kd(4));
    press(kd(0));
    enter(K_ENT, 12'h000, 1'b0);
    wait_done(0);

    // 99 + 99, third digit rejected
    press(kd(9));
    press(kd(9));
    press(kd(7));
    chk("t3_overflow_ign", disp_bcd, 12'h099);
    chk("t3_err", err, ERR_EN);
    tick();
    chk("t3_err_once", err, 0);
    ab(0, 0, K_ADD, 9, 9);
    chk("t3_b99", disp_bcd, 12'h099);
    enter(K_ENT, 12'h198, 1'b0);
    wait_done(0);

    // 2 - 5 with operator replacement allowed only before the first B digit
    press(K_ESC);
    press(kd(2));
    press(K_ADD);
    press(K_SUB);
    chk("op_replace", op_code, 2);
    press(kd(5));
    press(K_ADD);
    chk("op_locked", op_code, 2);
    chk("op_locked_err", err, ERR_EN);
    enter(K_ENT, 12'h003, 1'b1);
    wait_done(0);

    // keys injected during busy are dropped
    ab(1, 2, K_ADD, 3, 4);
    enter(K_ENT, 12'h046, 1'b0);
    press(kd(7));
    chk("t4_err_calc", err, ERR_EN);
    press(K_ESC);
    chk("t4_disp_hold", disp_bcd, 12'h034);
    chk("t4_busy_hold", busy, 1);
    wait_done(2);
    press(K_ESC);
    chk("t4_esc_disp", disp_bcd, 0);
    chk("t4_esc_op", op_code, 0);
    chk("t4_esc_neg", neg, 0);
    press(kd(5));
    chk("t4_enter_a", disp_bcd, 12'h005);

    // reset asserted mid-calculation
    press(K_ESC);
    press(kd(1));
    press(K_ADD);
    press(kd(2));
    press(K_ENT);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_disp", disp_bcd, 0);
    chk("t5_op", op_code, 0);
    chk("t5_neg", neg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_no_done", done_pulse, 0);
    press(kd(7));
    press(K_ADD);
    press(kd(1));
    enter(K_ENT, 12'h008, 1'b0);
    wait_done(0);

    // leaving DONE with a digit, then keys rejected in ENTER_A
    ab(1, 2, K_ADD, 3, 4);
    enter(K_ENT, 12'h046, 1'b0);
    wait_done(0);
    press(kd(5));
    chk("t6_disp", disp_bcd, 12'h005);
    chk("t6_neg", neg, 0);
    chk("t6_op", op_code, 0);
    press(K_UNK);
    chk("t6_unk_disp", disp_bcd, 12'h005);
    chk("t6_unk_err", err, ERR_EN);
    press(K_ENT);
    chk("t6_ent_busy", busy, 0);
    chk("t6_ent_err", err, ERR_EN);
    press(kd(3));
    chk("t6_still_a", disp_bcd, 12'h053);
    chk("t6_op_none", op_code, 0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
